// File: rtl/keys_debounce.sv
// keys_debounce: synchronizes and debounces a vector of active-low key inputs.
// A shared prescaler tick samples every key. A key's stable level changes only
// after DEBOUNCE_CNT consecutive tick samples that differ from the current level.
//
// Ports:
//   clk_i      core clock
//   rst_n_i    asynchronous active-low reset
//   keys_i     raw, asynchronous, bouncing key levels (1 = released, 0 = pressed)
//   keys_o     debounced stable key levels
//   keys_chg_o one-cycle strobe, high in the first cycle keys_o holds a new value
//   tick_o     debug strobe, high in the cycle after the prescaler samples
module keys_debounce #(
  parameter int unsigned NUM_KEYS     = 61,
  parameter int unsigned TICK_DIV     = 780,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic                keys_chg_o,
  output logic                tick_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [PRE_W-1:0]    r_pre;
  logic [CNT_W-1:0]    r_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_keys;
  logic                r_chg;
  logic                r_tick;

  logic                w_tick;
  logic [NUM_KEYS-1:0] w_keys_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt [NUM_KEYS];

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= keys_i;
      r_sync2 <= r_sync1;
    end
  end

  // Shared sample prescaler, counts 0..TICK_DIV-1.
  assign w_tick = (r_pre == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Per-key integrating debounce; a matching sample restarts the count.
  always_comb begin
    w_keys_nxt = r_keys;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_cnt_nxt[k] = r_cnt[k];
    end
    if (w_tick) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (r_sync2[k] == r_keys[k]) begin
          w_cnt_nxt[k] = '0;
        end else if (r_cnt[k] == CNT_W'(DEBOUNCE_CNT - 1)) begin
          w_keys_nxt[k] = r_sync2[k];
          w_cnt_nxt[k]  = '0;
        end else begin
          w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_cnt[k] <= '0;
      end
      r_keys <= '1;
      r_chg  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_cnt[k] <= w_cnt_nxt[k];
      end
      r_keys <= w_keys_nxt;
      // Any number of keys flipping on one tick yields a single strobe.
      r_chg  <= (w_keys_nxt != r_keys);
      r_tick <= w_tick;
    end
  end

  assign keys_o     = r_keys;
  assign keys_chg_o = r_chg;
  assign tick_o     = r_tick;

endmodule

// File: tb/tb_keys_debounce.sv
// tb_keys_debounce: directed bench for keys_debounce with a change scoreboard.
// Expected key-vector changes are queued with the clock edge at which they must
// appear; a monitor checks keys_o, keys_chg_o and tick_o every cycle.
module tb_keys_debounce;

  localparam int unsigned NK = 61;
  localparam int unsigned TD = 4;
  localparam int unsigned DC = 3;

  typedef struct {
    int          edge_n;
    logic [NK-1:0] keys;
  } exp_t;

  logic          clk_i   = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [NK-1:0] keys_i  = '1;
  logic [NK-1:0] keys_o;
  logic          keys_chg_o;
  logic          tick_o;

  exp_t          q[$];
  logic [NK-1:0] exp_keys = '1;
  logic [NK-1:0] mdl      = '1;
  int            ecnt     = 0;
  int            n_assert = 0;
  int            n_fail   = 0;

  keys_debounce #(.NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_CNT(DC)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .keys_i     (keys_i),
    .keys_o     (keys_o),
    .keys_chg_o (keys_chg_o),
    .tick_o     (tick_o)
  );

  always #5 clk_i = ~clk_i;

  // Edges counted since reset release.
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ecnt = 0;
    else          ecnt = ecnt + 1;
  end

  // Edge at which a level driven now (with ecnt == c) must be accepted:
  // two sync edges, then DC tick samples.
  function automatic int accept_edge(input int c);
    int t;
    t = c + 3;
    if (t < int'(TD)) t = int'(TD);
    t = ((t + int'(TD) - 1) / int'(TD)) * int'(TD);
    return t + int'(TD) * (int'(DC) - 1);
  endfunction

  // Per-cycle monitor, sampling 1 time unit after the active edge.
  always @(posedge clk_i) begin
    logic exp_chg;
    logic exp_tick;
    #1;
    while (q.size() > 0 && q[0].edge_n < ecnt) void'(q.pop_front());
    exp_chg = 1'b0;
    if (q.size() > 0 && q[0].edge_n == ecnt) begin
      exp_chg  = 1'b1;
      exp_keys = q[0].keys;
      void'(q.pop_front());
    end
    exp_tick = (ecnt >= int'(TD)) && (ecnt % int'(TD) == 0);
    n_assert++;
    assert (keys_o === exp_keys) else begin
      n_fail++;
      $error("FAIL keys_o @edge %0d: observed %h expected %h", ecnt, keys_o, exp_keys);
    end
    n_assert++;
    assert (keys_chg_o === exp_chg) else begin
      n_fail++;
      $error("FAIL keys_chg_o @edge %0d: observed %b expected %b", ecnt, keys_chg_o, exp_chg);
    end
    n_assert++;
    assert (tick_o === exp_tick) else begin
      n_fail++;
      $error("FAIL tick_o @edge %0d: observed %b expected %b", ecnt, tick_o, exp_tick);
    end
  end

  // Return at the negedge inside the cycle where tick_o is high.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!tick_o && n < 3 * int'(TD));
    if (!tick_o) begin
      n_fail++;
      $display("FAIL wait_tick: observed no tick within %0d cycles", n);
    end
  endtask

  task automatic push_change();
    exp_t e;
    e.edge_n = accept_edge(ecnt);
    e.keys   = mdl;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    n_assert++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d pending changes expected 0", q.size());
    end
  endtask

  initial begin
    // 1: reset, then idle with all keys released.
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (100) @(negedge clk_i);

    // 2: steady press of key 5.
    wait_tick();
    keys_i[5] = 1'b0;
    mdl[5]    = 1'b0;
    push_change();
    wait_drain();

    // 3: key 7 bounces, never DC consecutive low samples.
    wait_tick();
    keys_i[7] = 1'b0;
    wait_tick();
    wait_tick();
    keys_i[7] = 1'b1;
    wait_tick();
    keys_i[7] = 1'b0;
    wait_tick();
    wait_tick();
    keys_i[7] = 1'b1;
    repeat (5) wait_tick();

    // 4: keys 0 and 60 pressed together.
    wait_tick();
    keys_i[0]  = 1'b0;
    keys_i[60] = 1'b0;
    mdl[0]     = 1'b0;
    mdl[60]    = 1'b0;
    push_change();
    wait_drain();

    // 5: release key 5.
    wait_tick();
    keys_i[5] = 1'b1;
    mdl[5]    = 1'b1;
    push_change();
    wait_drain();

    // 6: press key 9, reset mid-count; keys 0, 60, 9 re-debounce afterwards.
    wait_tick();
    keys_i[9] = 1'b0;
    wait_tick();
    wait_tick();
    rst_n_i  = 1'b0;
    q.delete();
    exp_keys = '1;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    mdl     = '1;
    mdl[0]  = 1'b0;
    mdl[60] = 1'b0;
    mdl[9]  = 1'b0;
    push_change();
    wait_drain();
    repeat (20) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
